// File: rtl/lcd_bus_responder.sv
// LCD-controller end of the 8-bit en/rs/rw/db bus: command decode, DDRAM, reads and scan-out.
// Define LCD_BUS_RESPONDER_BUSY_EN for the DEPTH-cycle CLEAR state with busy/err_busy_wr.
module lcd_bus_responder #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lcd_en,
  input  logic          lcd_rs,
  input  logic          lcd_rw,
  input  logic [7:0]    lcd_db_i,
  output logic [7:0]    lcd_db_o,
  output logic          lcd_db_oe,
  input  logic [AW-1:0] scan_addr,
  output logic [7:0]    scan_data,
  output logic          wr_strobe,
  output logic          wr_is_data,
  output logic [7:0]    wr_byte,
  output logic          busy,
  output logic          err_busy_wr
);

  localparam logic [7:0] BLANK = 8'h20;

  logic          en_s1_q, en_sync_q, en_prev_q;
  logic          rs_s1_q, rs_sync_q;
  logic          rw_s1_q, rw_sync_q;
  logic [7:0]    db_s1_q, db_sync_q;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] ac_q, ac_d;
  logic          id_q, id_d;
  logic          err_q, err_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic          wr_is_data_q, wr_is_data_d;
  logic [7:0]    wr_byte_q, wr_byte_d;
  logic [7:0]    scan_data_q, scan_data_d;
  logic          fall;

`ifdef LCD_BUS_RESPONDER_BUSY_EN
  typedef enum logic {S_IDLE, S_CLEAR} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  assign busy = (state_q == S_CLEAR);
`else
  assign busy = 1'b0;
`endif

  function automatic logic [AW-1:0] ac_step(input logic [AW-1:0] a, input logic inc);
    return inc ? a + 1'b1 : a - 1'b1;
  endfunction

  assign fall = en_prev_q & ~en_sync_q;

  // Bus side: decode the completed transfer, then let the clear engine override on exit.
  always_comb begin
    mem_d        = mem_q;
    ac_d         = ac_q;
    id_d         = id_q;
    err_d        = err_q;
    wr_strobe_d  = 1'b0;
    wr_is_data_d = wr_is_data_q;
    wr_byte_d    = wr_byte_q;
    scan_data_d  = mem_q[scan_addr];
`ifdef LCD_BUS_RESPONDER_BUSY_EN
    state_d      = state_q;
    ptr_d        = ptr_q;
`endif
    if (fall && !rw_sync_q) begin
      wr_strobe_d  = 1'b1;
      wr_is_data_d = rs_sync_q;
      wr_byte_d    = db_sync_q;
      if (busy) begin
        err_d = 1'b1;
      end else if (rs_sync_q) begin
        mem_d[ac_q] = db_sync_q;
        ac_d        = ac_step(ac_q, id_q);
      end else if (db_sync_q[7]) begin
        ac_d = db_sync_q[AW-1:0];
      end else if (db_sync_q[6:3] == 4'b0000) begin
        if (db_sync_q[2]) begin
          id_d = db_sync_q[1];
        end else if (db_sync_q[1]) begin
          ac_d = '0;
        end else if (db_sync_q[0]) begin
`ifdef LCD_BUS_RESPONDER_BUSY_EN
          state_d = S_CLEAR;
          ptr_d   = '0;
`else
          for (int i = 0; i < DEPTH; i++) mem_d[i] = BLANK;
          ac_d = '0;
          id_d = 1'b1;
`endif
        end
      end
    end else if (fall && rw_sync_q && rs_sync_q) begin
      ac_d = ac_step(ac_q, id_q);
    end
`ifdef LCD_BUS_RESPONDER_BUSY_EN
    if (state_q == S_CLEAR) begin
      mem_d[ptr_q] = BLANK;
      ptr_d        = ptr_q + 1'b1;
      if (ptr_q == {AW{1'b1}}) begin
        state_d = S_IDLE;
        ac_d    = '0;
        id_d    = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_s1_q      <= 1'b0;
      en_sync_q    <= 1'b0;
      en_prev_q    <= 1'b0;
      rs_s1_q      <= 1'b0;
      rs_sync_q    <= 1'b0;
      rw_s1_q      <= 1'b0;
      rw_sync_q    <= 1'b0;
      db_s1_q      <= 8'h00;
      db_sync_q    <= 8'h00;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= BLANK;
      ac_q         <= '0;
      id_q         <= 1'b1;
      err_q        <= 1'b0;
      wr_strobe_q  <= 1'b0;
      wr_is_data_q <= 1'b0;
      wr_byte_q    <= 8'h00;
      scan_data_q  <= 8'h00;
`ifdef LCD_BUS_RESPONDER_BUSY_EN
      state_q      <= S_IDLE;
      ptr_q        <= '0;
`endif
    end else begin
      en_s1_q      <= lcd_en;
      en_sync_q    <= en_s1_q;
      en_prev_q    <= en_sync_q;
      rs_s1_q      <= lcd_rs;
      rs_sync_q    <= rs_s1_q;
      rw_s1_q      <= lcd_rw;
      rw_sync_q    <= rw_s1_q;
      db_s1_q      <= lcd_db_i;
      db_sync_q    <= db_s1_q;
      mem_q        <= mem_d;
      ac_q         <= ac_d;
      id_q         <= id_d;
      err_q        <= err_d;
      wr_strobe_q  <= wr_strobe_d;
      wr_is_data_q <= wr_is_data_d;
      wr_byte_q    <= wr_byte_d;
      scan_data_q  <= scan_data_d;
`ifdef LCD_BUS_RESPONDER_BUSY_EN
      state_q      <= state_d;
      ptr_q        <= ptr_d;
`endif
    end
  end

  // Read data is driven only while a synchronized read strobe is high.
  always_comb begin
    lcd_db_oe = en_sync_q & rw_sync_q;
    lcd_db_o  = 8'h00;
    if (lcd_db_oe) begin
      lcd_db_o = rs_sync_q ? mem_q[ac_q] : {busy, 7'(ac_q)};
    end
  end

  assign scan_data   = scan_data_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_is_data  = wr_is_data_q;
  assign wr_byte     = wr_byte_q;
  assign err_busy_wr = err_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Randomized bench for lcd_bus_responder against a transaction-level model of the LCD bus.
module tb_lcd_bus_responder;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lcd_en = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic [7:0]    lcd_db_i = 8'h00;
  logic [7:0]    lcd_db_o;
  logic          lcd_db_oe;
  logic [AW-1:0] scan_addr = '0;
  logic [7:0]    scan_data;
  logic          wr_strobe, wr_is_data;
  logic [7:0]    wr_byte;
  logic          busy, err_busy_wr;

  lcd_bus_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_db_i(lcd_db_i), .lcd_db_o(lcd_db_o), .lcd_db_oe(lcd_db_oe),
    .scan_addr(scan_addr), .scan_data(scan_data), .wr_strobe(wr_strobe),
    .wr_is_data(wr_is_data), .wr_byte(wr_byte), .busy(busy), .err_busy_wr(err_busy_wr)
  );

  always #5 clk = ~clk;

`ifdef LCD_BUS_RESPONDER_BUSY_EN
  localparam bit BUSY_EN = 1'b1;
`else
  localparam bit BUSY_EN = 1'b0;
`endif

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] m_mem [DEPTH];
  int         m_ac;
  bit         m_id;
  bit         m_busy;
  bit         m_err;

  int busy_run = 0;
  int busy_last = 0;
  always @(negedge clk) begin
    if (busy) busy_run++;
    else if (busy_run != 0) begin
      busy_last = busy_run;
      busy_run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic void m_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h20;
    m_ac = 0; m_id = 1; m_busy = 0; m_err = 0;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h20;
    m_ac = 0; m_id = 1;
  endfunction

  function automatic void m_move();
    m_ac = m_id ? (m_ac + 1) % DEPTH : (m_ac + DEPTH - 1) % DEPTH;
  endfunction

  function automatic void m_write(input bit rs, input logic [7:0] b);
    if (m_busy) begin
      m_err = 1;
    end else if (rs) begin
      m_mem[m_ac] = b;
      m_move();
    end else if (b >= 8'h80) m_ac = int'(b) % DEPTH;
    else if (b >= 8'h08) begin end
    else if (b >= 8'h04) m_id = b[1];
    else if (b >= 8'h02) m_ac = 0;
    else if (b == 8'h01) begin
      if (BUSY_EN) m_busy = 1;
      else m_clear();
    end
  endfunction

  task automatic bus_wr(input bit rs, input logic [7:0] b);
    int n = 0;
    logic isd = 1'b0;
    logic [7:0] wb = 8'h00;
    @(posedge clk); #1;
    lcd_rs = rs; lcd_rw = 1'b0; lcd_db_i = b; lcd_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 lcd_en = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (wr_strobe) begin n++; isd = wr_is_data; wb = wr_byte; end
    end
    chk("wr_strobe_count", n, 1);
    chk("wr_is_data", isd, rs);
    chk("wr_byte", wb, b);
    m_write(rs, b);
    chk("err_busy_wr", err_busy_wr, m_err);
  endtask

  task automatic bus_rd(input bit rs);
    int n = 0;
    logic [7:0] exp;
    @(posedge clk); #1;
    lcd_rs = rs; lcd_rw = 1'b1; lcd_en = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    exp = rs ? m_mem[m_ac] : {m_busy, 7'(m_ac)};
    chk(rs ? "rd_oe_data" : "rd_oe_status", lcd_db_oe, 1'b1);
    chk(rs ? "rd_data" : "rd_status", lcd_db_o, exp);
    @(posedge clk); #1 lcd_en = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (wr_strobe) n++;
    end
    chk("rd_no_strobe", n, 0);
    chk("rd_oe_off", lcd_db_oe, 1'b0);
    chk("rd_db_idle", lcd_db_o, 8'h00);
    if (rs) m_move();
  endtask

  task automatic scan_all();
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1 scan_addr = AW'(i);
      @(posedge clk); #1;
      chk($sformatf("scan%0d", i), scan_data, m_mem[i]);
    end
  endtask

  task automatic wait_clear_done();
    int k = 0;
    while (busy && k < 100) begin @(negedge clk); k++; end
    chk("busy_done", busy, 1'b0);
    repeat (2) @(negedge clk);
    chk("busy_len", busy_last, DEPTH);
    m_busy = 0;
    m_clear();
  endtask

  task automatic apply_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    lcd_en = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_db_i = 8'h00;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err_busy_wr, 1'b0);
    chk("rst_strobe", wr_strobe, 1'b0);
    chk("rst_wr_byte", wr_byte, 8'h00);
    chk("rst_wr_is_data", wr_is_data, 1'b0);
    chk("rst_scan", scan_data, 8'h00);
    chk("rst_oe", lcd_db_oe, 1'b0);
    chk("rst_db_o", lcd_db_o, 8'h00);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    m_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    int op;
    m_reset();
    apply_reset();
    scan_all();
    bus_rd(0);

    // wrap on increment
    bus_wr(0, 8'h9F);
    bus_wr(1, 8'h41);
    bus_wr(1, 8'h42);
    chk("dir_ddram31", m_mem[31], 8'h41);
    scan_all();

    // decrement wraps to DEPTH-1
    bus_wr(0, 8'h04);
    bus_wr(0, 8'h80);
    bus_wr(1, 8'h55);
    bus_rd(0);
    bus_wr(0, 8'h06);

    // data read at AC=3
    bus_wr(0, 8'h83);
    bus_wr(1, 8'h48);
    bus_wr(0, 8'h83);
    bus_rd(1);
    bus_rd(0);

    // clear with a write landing during it
    bus_wr(0, 8'h01);
`ifdef LCD_BUS_RESPONDER_BUSY_EN
    bus_rd(0);
    bus_wr(1, 8'h33);
    chk("err_after_busy_wr", err_busy_wr, 1'b1);
    wait_clear_done();
`else
    bus_wr(1, 8'h33);
`endif
    bus_rd(0);
    scan_all();

    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 9);
      b = 8'($urandom);
      case (op)
        0, 1, 2, 3: bus_wr(1, b);
        4: bus_wr(0, 8'h80 | b);
        5: bus_wr(0, 8'h04 | (b & 8'h03));
        6: bus_wr(0, 8'h02 | (b & 8'h01));
        7: bus_wr(0, (b & 8'h01) ? 8'h00 : (8'h08 | (b & 8'h77)));
        8: bus_rd(1);
        default: bus_rd(0);
      endcase
    end
    scan_all();

    // reset in the middle of a clear
    bus_wr(1, 8'h77);
    bus_wr(0, 8'h01);
    bus_wr(1, 8'h66);
    apply_reset();
    scan_all();
    bus_rd(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lcd_bus_responder.md
Name: lcd_bus_responder

Overview:
- Synthesizable model of the LCD controller end of the 8-bit parallel LCD bus (en/rs/rw/db) that our display driver writes.
- Samples the bus, decodes a command subset (clear, home, entry mode, set DDRAM address), and stores data bytes in an internal DDRAM.
- Answers status and data reads, and exposes a scan-out port so on-chip logic or the bench can inspect what the driver wrote.
- Used as an in-fabric loopback target and as the checker-side model for driver verification.

Parameters:
- DEPTH, 32, number of DDRAM character cells; must equal 2**AW.
- AW, 5, width of the address counter (AC) and of scan_addr.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- lcd_en, input, 1, bus enable strobe; a transfer completes on its falling edge.
- lcd_rs, input, 1, register select: 0 = command/status, 1 = data.
- lcd_rw, input, 1, 0 = write, 1 = read.
- lcd_db_i, input, 8, bus data from the driver.
- lcd_db_o, output, 8, read data returned to the bus.
- lcd_db_oe, output, 1, high while the responder drives the bus.
- scan_addr, input, AW, DDRAM scan-out address.
- scan_data, output, 8, DDRAM[scan_addr], registered, 1-cycle latency.
- wr_strobe, output, 1, one-cycle pulse per accepted or ignored bus write.
- wr_is_data, output, 1, lcd_rs of that write; valid with wr_strobe.
- wr_byte, output, 8, data byte of that write; valid with wr_strobe.
- busy, output, 1, clear operation in progress.
- err_busy_wr, output, 1, sticky flag: a write arrived while busy.

Behaviour:
- Synchronization: lcd_en, lcd_rs, lcd_rw and lcd_db_i each pass through 2 flops. A third en register detects edges. The falling edge is detected in cycle N when en_prev=1 and en_sync=0. The rs/rw/db values used are the synchronized values from the same cycle.
- Write (rw=0) on edge cycle N: effects commit at the end of N. wr_strobe/wr_is_data/wr_byte are asserted during N+1. Total pin-to-strobe latency is 3–4 clk.
- Data write (rs=1): DDRAM[AC] <= byte, then AC moves by the entry direction. Increment: AC+1 mod DEPTH (DEPTH-1 wraps to 0). Decrement: AC-1 mod DEPTH (0 wraps to DEPTH-1).
- Command decode (rs=0), highest set bit wins:
  - 0x80 | a: AC <= a[AW-1:0].
  - 0x04–0x07 (entry mode): ID <= byte[1] (1 = increment).
  - 0x02–0x03 (home): AC <= 0.
  - 0x01 (clear): enter CLEAR state.
  - Everything else is ignored but still strobed.
- State machine:
  - IDLE to CLEAR on a clear command. CLEAR holds a fill pointer starting at 0, writes 0x20 to one cell per cycle, and leaves after DEPTH cycles.
  - On exit: AC=0, ID=1, busy=0, return to IDLE.
  - busy=1 for exactly the DEPTH cycles spent in CLEAR.
- Write while busy: the write is ignored (no DDRAM/AC/ID change). wr_strobe still pulses. err_busy_wr sets and is cleared only by reset.
- Read (rw=1):
  - While en_sync=1 and rw_sync=1: lcd_db_oe=1.
  - lcd_db_o = {busy, AC zero-extended to 7 bits} when rs=0, or DDRAM[AC] when rs=1. It is combinational from the synchronized rs.
  - On the falling edge with rw=1 and rs=1, AC moves by ID. A status read leaves AC unchanged. Reads never pulse wr_strobe.
  - Otherwise lcd_db_oe=0 and lcd_db_o=0x00.
- Reset values:
  - All DDRAM cells 0x20; AC=0; ID=1; state IDLE.
  - busy=0, err_busy_wr=0, wr_strobe=0, wr_is_data=0, wr_byte=0x00.
  - lcd_db_o=0x00, lcd_db_oe=0, scan_data=0x00, all sync flops 0.
- Reset mid-CLEAR aborts immediately to the reset values above; all cells read 0x20.
- A scan read of a cell being written in the same cycle returns the old value. The new value appears on the next scan.

Optional Feature:
- Macro: LCD_BUS_RESPONDER_BUSY_EN.
- Defined: clear is the DEPTH-cycle CLEAR state as described, with busy and err_busy_wr active.
- Undefined: clear fills all cells with 0x20 in the single commit cycle. busy is tied 0 and the status read bit 7 is always 0. err_busy_wr is tied 0. No CLEAR state exists.

Test Plan:
- Reset, then scan all addresses -> every scan_data = 0x20; busy=0, lcd_db_oe=0, AC=0.
- Write command 0x80|0x1F, then data 0x41, 0x42 (ID=1) -> DDRAM[31]=0x41, DDRAM[0]=0x42 (wrap); wr_strobe pulses twice with wr_is_data=1 and wr_byte 0x41 then 0x42.
- Write command 0x04 (ID=0), 0x80|0x00, then data 0x55 -> DDRAM[0]=0x55; a status read returns 0x1F (AC wrapped to DEPTH-1, busy=0).
- Write 0x01, then data 0x33 two cycles later (BUSY_EN defined) -> busy=1 for 32 cycles; 0x33 not stored; err_busy_wr=1; afterwards all cells 0x20, AC=0; a status read during CLEAR shows bit 7 = 1.
- Data read at AC=3 with DDRAM[3]=0x48 -> lcd_db_oe=1 and lcd_db_o=0x48 while en is high; AC=4 after the falling edge; no wr_strobe.
- Assert rst_n low 10 cycles into CLEAR -> busy=0 and err_busy_wr=0 immediately; all cells 0x20 after reset release.
